// File: rtl/seq_pkg.sv
// seq_pkg: FSM encoding and default geometry shared by the state_sequencer slice.
package seq_pkg;

  // Sequencer control FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } seq_fsm_e;

  // Default sequence geometry: six decoded digits on a 3-bit state bus
  localparam int unsigned DEFAULT_NUM_STATES = 6;
  localparam int unsigned DEFAULT_STATE_W    = 3;

endpackage : seq_pkg

// File: rtl/dwell_timer.sv
// dwell_timer: counts clocks spent in the current state and flags the last one.
// o_expire is high in the enabled cycle where count == dwell_reg-1, so a state
// is held exactly dwell_reg enabled clocks. load (new start) and clear (step or
// stop) both restart the count from zero; when disabled the count freezes.
module dwell_timer #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_load,
  input  logic               i_enable,
  input  logic               i_clear,
  input  logic [DWELL_W-1:0] i_dwell_reg,
  output logic               o_expire
);

  localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

  logic [DWELL_W-1:0] count_q;
  logic [DWELL_W-1:0] count_d;

  // dwell_reg is never zero, so dwell_reg-1 cannot underflow
  assign o_expire = i_enable && (count_q == (i_dwell_reg - ONE));

  // Next count: restart on load/clear, wrap on expiry, otherwise step or hold
  always_comb begin
    count_d = count_q;
    if (i_load || i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = o_expire ? '0 : (count_q + ONE);
    end
  end

  // Count register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : dwell_timer

// File: rtl/state_sequencer.sv
// state_sequencer: steps the 3-bit state feeding the 7-segment state decoder
// through 0..NUM_STATES-1, holding each state for a programmable dwell time.
// Commands (highest first): stop > pause > start > step.
// Optional build macro SEQ_REVERSE_EN adds i_dir for descending sequences.
module state_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned NUM_STATES = DEFAULT_NUM_STATES,
  parameter int unsigned STATE_W    = DEFAULT_STATE_W,
  parameter int unsigned DWELL_W    = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
`ifdef SEQ_REVERSE_EN
  input  logic               i_dir,
`endif
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_pause,
  input  logic               i_step,
  input  logic [DWELL_W-1:0] i_dwell,
  output logic [STATE_W-1:0] o_state,
  output logic               o_tick,
  output logic               o_wrap,
  output logic               o_running,
  output logic               o_paused
);

  localparam logic [STATE_W-1:0] LAST_STATE = STATE_W'(NUM_STATES - 1);
  localparam logic [STATE_W-1:0] STATE_ONE  = STATE_W'(1);
  localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);

  seq_fsm_e           fsm_q,   fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               tick_q,  tick_d;
  logic               wrap_q,  wrap_d;

  logic               tmr_load;
  logic               tmr_enable;
  logic               tmr_clear;
  logic               tmr_expire;
  logic               advance;
  logic [STATE_W-1:0] adv_state;
  logic               adv_wrap;

  dwell_timer #(
    .DWELL_W(DWELL_W)
  ) u_dwell_timer (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_load     (tmr_load),
    .i_enable   (tmr_enable),
    .i_clear    (tmr_clear),
    .i_dwell_reg(dwell_q),
    .o_expire   (tmr_expire)
  );

  // Neighbour of the current state in the active direction, and whether that move wraps
  always_comb begin
    adv_wrap  = (state_q == LAST_STATE);
    adv_state = adv_wrap ? '0 : (state_q + STATE_ONE);
`ifdef SEQ_REVERSE_EN
    if (i_dir) begin
      adv_wrap  = (state_q == '0);
      adv_state = adv_wrap ? LAST_STATE : (state_q - STATE_ONE);
    end
`endif
  end

  // Command decode: only the highest-priority command acts in a given cycle
  always_comb begin
    fsm_d      = fsm_q;
    state_d    = state_q;
    dwell_d    = dwell_q;
    tick_d     = 1'b0;
    wrap_d     = 1'b0;
    tmr_load   = 1'b0;
    tmr_enable = 1'b0;
    tmr_clear  = 1'b0;
    advance    = 1'b0;

    if (i_stop) begin
      fsm_d     = IDLE;
      state_d   = '0;
      tmr_clear = 1'b1;
    end else if (i_pause) begin
      // Pause only has meaning in RUN, but it still masks start/step elsewhere
      if (fsm_q == RUN) begin
        fsm_d = PAUSE;
      end
    end else begin
      case (fsm_q)
        IDLE: begin
          if (i_start) begin
            fsm_d    = RUN;
            state_d  = '0;
            dwell_d  = (i_dwell == '0) ? DWELL_ONE : i_dwell;
            tmr_load = 1'b1;
          end else if (i_step) begin
            advance   = 1'b1;
            tmr_clear = 1'b1;
          end
        end
        RUN: begin
          // A repeated start is deliberately ignored here
          tmr_enable = 1'b1;
          advance    = tmr_expire;
        end
        PAUSE: begin
          if (i_start) begin
            fsm_d = RUN;
          end else if (i_step) begin
            advance   = 1'b1;
            tmr_clear = 1'b1;
          end
        end
        default: begin
          fsm_d     = IDLE;
          state_d   = '0;
          tmr_clear = 1'b1;
        end
      endcase
    end

    if (advance) begin
      state_d = adv_state;
      tick_d  = 1'b1;
      wrap_d  = adv_wrap;
    end
  end

  // FSM, state, dwell and pulse registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      dwell_q <= DWELL_ONE;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      dwell_q <= dwell_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  assign o_state   = state_q;
  assign o_tick    = tick_q;
  assign o_wrap    = wrap_q;
  assign o_running = (fsm_q == RUN);
  assign o_paused  = (fsm_q == PAUSE);

endmodule : state_sequencer

// File: tb/tb_state_sequencer.sv
// tb_state_sequencer: directed scenarios plus randomized command bursts, all
// scored cycle by cycle against a behavioural model of the sequencer.
// Build with +define+SEQ_REVERSE_EN to exercise the descending direction.
module tb_state_sequencer;

  localparam int N       = 6;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic        clk;
  logic        rst_n;
  logic        i_start;
  logic        i_stop;
  logic        i_pause;
  logic        i_step;
  logic        i_dir;
  logic [15:0] i_dwell;
  logic [2:0]  o_state;
  logic        o_tick;
  logic        o_wrap;
  logic        o_running;
  logic        o_paused;

  int n_checks;
  int n_pass;
  int cyc_no;

  // Reference model: mode, displayed position, clocks spent in RUN at this position
  int m_mode;
  int m_pos;
  int m_elapsed;
  int m_dwell;
  int m_tick;
  int m_wrap;

  state_sequencer dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
`ifdef SEQ_REVERSE_EN
    .i_dir    (i_dir),
`endif
    .i_start  (i_start),
    .i_stop   (i_stop),
    .i_pause  (i_pause),
    .i_step   (i_step),
    .i_dwell  (i_dwell),
    .o_state  (o_state),
    .o_tick   (o_tick),
    .o_wrap   (o_wrap),
    .o_running(o_running),
    .o_paused (o_paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_no);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_pos     = 0;
    m_elapsed = 0;
    m_dwell   = 1;
    m_tick    = 0;
    m_wrap    = 0;
  endtask

  // One clock of the sequencer as described in words: the strongest command wins
  task automatic model_step(input logic st, input logic sp, input logic pa,
                            input logic se, input int dw, input logic dr);
    bit adv;
    adv    = 0;
    m_tick = 0;
    m_wrap = 0;
    if (sp) begin
      m_mode    = M_IDLE;
      m_pos     = 0;
      m_elapsed = 0;
    end else if (pa) begin
      if (m_mode == M_RUN) m_mode = M_PAUSE;
    end else if (m_mode == M_IDLE) begin
      if (st) begin
        m_mode    = M_RUN;
        m_dwell   = (dw == 0) ? 1 : dw;
        m_pos     = 0;
        m_elapsed = 0;
      end else if (se) begin
        adv = 1;
      end
    end else if (m_mode == M_RUN) begin
      m_elapsed++;
      if (m_elapsed >= m_dwell) adv = 1;
    end else begin
      if (st) m_mode = M_RUN;
      else if (se) adv = 1;
    end
    if (adv) begin
      m_tick    = 1;
      m_elapsed = 0;
      if (dr) begin
        m_wrap = (m_pos == 0) ? 1 : 0;
        m_pos  = (m_pos + N - 1) % N;
      end else begin
        m_wrap = (m_pos == N - 1) ? 1 : 0;
        m_pos  = (m_pos + 1) % N;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_state"},   o_state,   m_pos);
    chk({tag, "_tick"},    o_tick,    m_tick);
    chk({tag, "_wrap"},    o_wrap,    m_wrap);
    chk({tag, "_running"}, o_running, (m_mode == M_RUN) ? 1 : 0);
    chk({tag, "_paused"},  o_paused,  (m_mode == M_PAUSE) ? 1 : 0);
  endtask

  // Drive one cycle of commands at the falling edge, score just after the rising edge
  task automatic cyc(input string tag, input logic st, input logic sp, input logic pa,
                     input logic se, input logic [15:0] dw, input logic dr);
    @(negedge clk);
    i_start = st;
    i_stop  = sp;
    i_pause = pa;
    i_step  = se;
    i_dwell = dw;
    i_dir   = dr;
    model_step(st, sp, pa, se, int'(dw), dr);
    @(posedge clk);
    #1;
    cyc_no++;
    check_outputs(tag);
  endtask

  task automatic idle_cycles(input string tag, input int n, input logic [15:0] dw);
    for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, 1'b0, 1'b0, dw, 1'b0);
  endtask

  // Assert reset between clock edges and check outputs before the next edge
  task automatic async_reset(input string tag);
    #2;
    i_start = 1'b0;
    i_stop  = 1'b0;
    i_pause = 1'b0;
    i_step  = 1'b0;
    i_dir   = 1'b0;
    rst_n   = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int wraps;
    n_checks = 0;
    n_pass   = 0;
    cyc_no   = 0;
    rst_n    = 1'b0;
    i_start  = 1'b0;
    i_stop   = 1'b0;
    i_pause  = 1'b0;
    i_step   = 1'b0;
    i_dir    = 1'b0;
    i_dwell  = 16'd0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset");
    rst_n = 1'b1;
    $display("reset: state=%0d running=%0d paused=%0d", o_state, o_running, o_paused);

    // Dwell 3: each state held three clocks, wrap only on 5->0
    cyc("t1", 1'b1, 1'b0, 1'b0, 1'b0, 16'd3, 1'b0);
    idle_cycles("t1", 20, 16'd3);
    $display("t1 dwell3: state=%0d after 21 cycles", o_state);

    // Dwell 0 behaves as 1: advance every clock
    cyc("t2", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    cyc("t2", 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 1'b0);
    idle_cycles("t2", 13, 16'd0);
    $display("t2 dwell0: state=%0d tick=%0d", o_state, o_tick);

    // Pause two clocks into state 2 with dwell 4, hold, resume
    cyc("t3", 1'b0, 1'b1, 1'b0, 1'b0, 16'd4, 1'b0);
    cyc("t3", 1'b1, 1'b0, 1'b0, 1'b0, 16'd4, 1'b0);
    idle_cycles("t3", 10, 16'd9);
    cyc("t3", 1'b0, 1'b0, 1'b1, 1'b0, 16'd9, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cyc("t3", 1'b0, 1'b0, 1'b0, 1'b0, 16'd9, 1'b0);
      chk("t3_hold_state", o_state, 2);
    end
    cyc("t3", 1'b1, 1'b0, 1'b0, 1'b0, 16'd9, 1'b0);
    chk("t3_resume0", o_state, 2);
    cyc("t3", 1'b0, 1'b0, 1'b0, 1'b0, 16'd9, 1'b0);
    chk("t3_resume1", o_state, 2);
    cyc("t3", 1'b0, 1'b0, 1'b0, 1'b0, 16'd9, 1'b0);
    chk("t3_resume2", o_state, 3);
    $display("t3 pause/resume: state=%0d", o_state);

    // Seven steps from IDLE: 1,2,3,4,5,0,1 with a single wrap
    cyc("t4", 1'b0, 1'b1, 1'b0, 1'b0, 16'd0, 1'b0);
    wraps = 0;
    for (int i = 0; i < 7; i++) begin
      cyc("t4", 1'b0, 1'b0, 1'b0, 1'b1, 16'd0, 1'b0);
      wraps += int'(o_wrap);
    end
    chk("t4_final_state", o_state, 1);
    chk("t4_wrap_count", wraps, 1);
    $display("t4 steps: state=%0d wraps=%0d", o_state, wraps);

    // Stop and pause together in RUN at state 4: stop wins
    cyc("t5", 1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 1'b0);
    chk("t5_start_state", o_state, 0);
    cyc("t5", 1'b0, 1'b1, 1'b0, 1'b0, 16'd5, 1'b0);
    cyc("t5", 1'b1, 1'b0, 1'b0, 1'b0, 16'd5, 1'b0);
    idle_cycles("t5", 20, 16'd5);
    chk("t5_at_state4", o_state, 4);
    cyc("t5", 1'b0, 1'b1, 1'b1, 1'b0, 16'd5, 1'b0);
    chk("t5_stop_state", o_state, 0);
    chk("t5_stop_running", o_running, 0);
    chk("t5_stop_paused", o_paused, 0);
    chk("t5_stop_tick", o_tick, 0);
    $display("t5 stop+pause: state=%0d running=%0d", o_state, o_running);

    // Asynchronous reset mid-RUN at state 3
    cyc("t6", 1'b1, 1'b0, 1'b0, 1'b0, 16'd2, 1'b0);
    idle_cycles("t6", 6, 16'd2);
    chk("t6_at_state3", o_state, 3);
    async_reset("t6_rst");
    $display("t6 async reset: state=%0d running=%0d", o_state, o_running);

`ifdef SEQ_REVERSE_EN
    // Descending run: 0,5,4,... with a wrap on 0->5
    cyc("t7", 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1);
    for (int i = 0; i < 8; i++) cyc("t7", 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 1'b1);
    $display("t7 reverse: state=%0d", o_state);
`endif

    // Randomized command bursts
    for (int b = 0; b < 30; b++) begin
      for (int i = 0; i < 100; i++) begin
        logic st, sp, pa, se, dr;
        logic [15:0] dw;
        sp = ($urandom_range(0, 99) < 3);
        pa = ($urandom_range(0, 99) < 6);
        st = ($urandom_range(0, 99) < 10);
        se = ($urandom_range(0, 99) < 10);
        dw = 16'($urandom_range(0, 6));
`ifdef SEQ_REVERSE_EN
        dr = 1'($urandom_range(0, 1));
`else
        dr = 1'b0;
`endif
        cyc("rnd", st, sp, pa, se, dw, dr);
        if ((b % 7 == 6) && (i == 50)) async_reset("rnd_rst");
      end
      $display("burst %0d: state=%0d running=%0d paused=%0d passed=%0d/%0d",
               b, o_state, o_running, o_paused, n_pass, n_checks);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_state_sequencer
